// File: rtl/ahb_slave_fabric.sv
// AHB-Lite slave-side fabric: address decoder, data-phase mux, default slave with two-cycle ERROR
// and saturating error counter. Optional stalled-slave timeout under `AHB_FABRIC_TIMEOUT_EN.
module ahb_slave_fabric #(
   parameter int NUM_S       = 4,
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter logic [NUM_S*ADDR_W-1:0] SLV_BASE = {32'h5300_0000, 32'h5100_0000,
                                                  32'h5000_0000, 32'h0000_0000},
   parameter logic [NUM_S*ADDR_W-1:0] SLV_MASK = {4{32'hFF00_0000}},
   parameter int TIMEOUT_CYC = 256
) (
   input  logic                    HCLK,
   input  logic                    HRESET,
   input  logic [ADDR_W-1:0]       HADDR,
   input  logic [1:0]              HTRANS,
   input  logic                    HWRITE,
   output logic [NUM_S-1:0]        HSEL_S,
   input  logic [NUM_S*DATA_W-1:0] HRDATA_S,
   input  logic [NUM_S-1:0]        HREADYOUT_S,
   input  logic [NUM_S-1:0]        HRESP_S,
   output logic                    HREADY,
   output logic [DATA_W-1:0]       HRDATA,
   output logic                    HRESP,
   output logic [7:0]              err_cnt,
   output logic                    timeout
);

   typedef enum logic [1:0] {DS_IDLE = 2'd0, DS_ERR1 = 2'd1, DS_ERR2 = 2'd2} ds_state_e;

   localparam logic [NUM_S:0] DS_SEL = {1'b1, {NUM_S{1'b0}}};

   ds_state_e           state_q, state_d;
   logic [NUM_S:0]      dsel_q, dsel_d;
   logic                dtrans_q, dtrans_d;
   logic [7:0]          err_cnt_q, err_cnt_d;
   logic [NUM_S-1:0]    hsel_s;
   logic                ds_hit_s;
   logic                found_s;
   logic [DATA_W-1:0]   sel_rdata_s;
   logic                sel_ready_s;
   logic                sel_resp_s;
   logic                hready_s;
   logic                hresp_s;
   logic                fire_s;
   logic                unused_ok_s;

   assign unused_ok_s = ^{HWRITE, HTRANS[0]};

   // Address decode, lowest matching index wins; no match falls to the default slave.
   always_comb begin
      hsel_s  = '0;
      found_s = 1'b0;
      for (int i = 0; i < NUM_S; i++) begin
         if (!found_s && ((HADDR & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W])) begin
            hsel_s[i] = 1'b1;
            found_s   = 1'b1;
         end else begin
            hsel_s[i] = 1'b0;
         end
      end
      ds_hit_s = ~found_s;
   end

   // AND-OR mux over the one-hot data-phase select; the default slave contributes zero data.
   always_comb begin
      sel_rdata_s = '0;
      sel_ready_s = 1'b0;
      sel_resp_s  = 1'b0;
      for (int i = 0; i < NUM_S; i++) begin
         sel_rdata_s = sel_rdata_s | ({DATA_W{dsel_q[i]}} & HRDATA_S[i*DATA_W +: DATA_W]);
         sel_ready_s = sel_ready_s | (dsel_q[i] & HREADYOUT_S[i]);
         sel_resp_s  = sel_resp_s  | (dsel_q[i] & HRESP_S[i]);
      end
      if (dsel_q[NUM_S]) begin
         hready_s = (state_q != DS_ERR1);
         hresp_s  = (state_q != DS_IDLE);
      end else begin
         hready_s = sel_ready_s;
         hresp_s  = sel_resp_s;
      end
   end

   // ERR1 is entered as the unmapped transfer enters its data phase so its first cycle already stalls.
   always_comb begin
      state_d   = state_q;
      dsel_d    = dsel_q;
      dtrans_d  = dtrans_q;
      err_cnt_d = err_cnt_q;
      case (state_q)
         DS_IDLE, DS_ERR2: begin
            if (fire_s || (hready_s && ds_hit_s && HTRANS[1])) begin
               state_d = DS_ERR1;
            end else begin
               state_d = DS_IDLE;
            end
         end
         DS_ERR1: begin
            if (dsel_q[NUM_S] && dtrans_q) begin
               state_d = DS_ERR2;
            end else begin
               state_d = DS_IDLE;
            end
         end
         default: state_d = DS_IDLE;
      endcase
      if (fire_s) begin
         dsel_d   = DS_SEL;
         dtrans_d = 1'b1;
      end else if (hready_s) begin
         dsel_d   = {ds_hit_s, hsel_s};
         dtrans_d = HTRANS[1];
      end else begin
         dsel_d   = dsel_q;
         dtrans_d = dtrans_q;
      end
      if ((state_q == DS_ERR1) && (state_d == DS_ERR2) && (err_cnt_q != 8'hFF)) begin
         err_cnt_d = err_cnt_q + 8'd1;
      end else begin
         err_cnt_d = err_cnt_q;
      end
   end

   // Fabric state registers.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_q   <= DS_IDLE;
         dsel_q    <= DS_SEL;
         dtrans_q  <= 1'b0;
         err_cnt_q <= 8'd0;
      end else begin
         state_q   <= state_d;
         dsel_q    <= dsel_d;
         dtrans_q  <= dtrans_d;
         err_cnt_q <= err_cnt_d;
      end
   end

`ifdef AHB_FABRIC_TIMEOUT_EN
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

   logic [15:0] timer_q, timer_d;
   logic        timeout_q;
   logic        stall_s;

   // Count consecutive stalled data-phase cycles of a real slave; fire on the last allowed one.
   always_comb begin
      stall_s = dtrans_q & ~dsel_q[NUM_S] & ~sel_ready_s;
      fire_s  = stall_s && (timer_q == TO_LAST);
      if (hready_s || fire_s) begin
         timer_d = 16'd0;
      end else if (stall_s) begin
         timer_d = timer_q + 16'd1;
      end else begin
         timer_d = timer_q;
      end
   end

   // Timeout counter and pulse register.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         timer_q   <= 16'd0;
         timeout_q <= 1'b0;
      end else begin
         timer_q   <= timer_d;
         timeout_q <= fire_s;
      end
   end

   assign timeout = timeout_q;
`else
   assign fire_s  = 1'b0;
   assign timeout = 1'b0;
`endif

   assign HSEL_S  = hsel_s;
   assign HREADY  = hready_s;
   assign HRESP   = hresp_s;
   assign HRDATA  = sel_rdata_s;
   assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_ahb_slave_fabric.sv
// Directed self-checking bench for ahb_slave_fabric (timeout scenario only with AHB_FABRIC_TIMEOUT_EN).
module tb_ahb_slave_fabric;

   logic          HCLK = 1'b0;
   logic          HRESET = 1'b1;
   logic [31:0]   HADDR = 32'h0;
   logic [1:0]    HTRANS = 2'b00;
   logic          HWRITE = 1'b0;
   logic [3:0]    HSEL_S;
   logic [127:0]  HRDATA_S = {32'h3333_CCCC, 32'hA5A5_A5A5, 32'h2222_DDDD, 32'h1111_EEEE};
   logic [3:0]    HREADYOUT_S = 4'b1111;
   logic [3:0]    HRESP_S = 4'b0000;
   logic          HREADY;
   logic [31:0]   HRDATA;
   logic          HRESP;
   logic [7:0]    err_cnt;
   logic          timeout;

   int            n_checks = 0;
   int            n_errors = 0;
   logic [7:0]    exp_cnt = 8'd0;

   logic [31:0]   dec_addr [7] = '{32'h5100_0004, 32'h0000_1234, 32'h50FF_FFFF, 32'h5300_0000,
                                   32'h6000_0000, 32'h5200_0000, 32'hFF00_0000};
   logic [3:0]    dec_exp  [7] = '{4'b0100, 4'b0001, 4'b0010, 4'b1000, 4'b0000, 4'b0000, 4'b0000};

   ahb_slave_fabric #(
      .NUM_S(4), .ADDR_W(32), .DATA_W(32),
      .SLV_BASE({32'h5300_0000, 32'h5100_0000, 32'h5000_0000, 32'h0000_0000}),
      .SLV_MASK({4{32'hFF00_0000}}),
      .TIMEOUT_CYC(8)
   ) dut (
      .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
      .HSEL_S(HSEL_S), .HRDATA_S(HRDATA_S), .HREADYOUT_S(HREADYOUT_S), .HRESP_S(HRESP_S),
      .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP), .err_cnt(err_cnt), .timeout(timeout)
   );

   always #5 HCLK = ~HCLK;

   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   task automatic test_reset();
      HRESET = 1'b1;
      HTRANS = 2'b00;
      repeat (2) tick();
      HRESET = 1'b0;
      #1;
      n_checks++; if (HREADY !== 1'b1) begin n_errors++; $display("FAIL reset_hready: got %b want 1", HREADY); end
      n_checks++; if (HRESP !== 1'b0) begin n_errors++; $display("FAIL reset_hresp: got %b want 0", HRESP); end
      n_checks++; if (HRDATA !== 32'h0) begin n_errors++; $display("FAIL reset_hrdata: got %h want 0", HRDATA); end
      n_checks++; if (err_cnt !== 8'd0) begin n_errors++; $display("FAIL reset_errcnt: got %0d want 0", err_cnt); end
      n_checks++; if (timeout !== 1'b0) begin n_errors++; $display("FAIL reset_timeout: got %b want 0", timeout); end
      exp_cnt = 8'd0;
   endtask

   task automatic test_decode();
      HTRANS = 2'b00;
      for (int i = 0; i < 7; i++) begin
         HADDR = dec_addr[i];
         #1;
         n_checks++;
         if (HSEL_S !== dec_exp[i]) begin
            n_errors++; $display("FAIL decode_hsel[%0d]: addr %h got %b want %b", i, HADDR, HSEL_S, dec_exp[i]);
         end
      end
      HADDR  = 32'h5100_0004;
      HTRANS = 2'b10;
      #1;
      tick();
      HTRANS = 2'b00;
      HADDR  = 32'h0;
      #1;
      n_checks++; if (HRDATA !== 32'hA5A5_A5A5) begin n_errors++; $display("FAIL decode_rdata: got %h want a5a5a5a5", HRDATA); end
      n_checks++; if (HRESP !== 1'b0) begin n_errors++; $display("FAIL decode_hresp: got %b want 0", HRESP); end
      n_checks++; if (HREADY !== 1'b1) begin n_errors++; $display("FAIL decode_hready: got %b want 1", HREADY); end
      tick();
   endtask

   task automatic test_unmapped();
      HADDR  = 32'h6000_0000;
      HTRANS = 2'b10;
      #1;
      tick();
      HTRANS = 2'b00;
      #1;
      n_checks++; if (HREADY !== 1'b0 || HRESP !== 1'b1) begin n_errors++; $display("FAIL unmapped_err1: got ready=%b resp=%b want 0/1", HREADY, HRESP); end
      n_checks++; if (HRDATA !== 32'h0) begin n_errors++; $display("FAIL unmapped_rdata: got %h want 0", HRDATA); end
      tick();
      exp_cnt = exp_cnt + 8'd1;
      n_checks++; if (HREADY !== 1'b1 || HRESP !== 1'b1) begin n_errors++; $display("FAIL unmapped_err2: got ready=%b resp=%b want 1/1", HREADY, HRESP); end
      n_checks++; if (err_cnt !== exp_cnt) begin n_errors++; $display("FAIL unmapped_errcnt: got %0d want %0d", err_cnt, exp_cnt); end
      tick();
      n_checks++; if (HREADY !== 1'b1 || HRESP !== 1'b0) begin n_errors++; $display("FAIL unmapped_after: got ready=%b resp=%b want 1/0", HREADY, HRESP); end
      for (int t = 0; t < 2; t++) begin
         HTRANS = (t == 0) ? 2'b00 : 2'b01;
         #1;
         tick();
         n_checks++;
         if (HREADY !== 1'b1 || HRESP !== 1'b0 || err_cnt !== exp_cnt) begin
            n_errors++; $display("FAIL unmapped_idle_busy[%0d]: got ready=%b resp=%b cnt=%0d want 1/0/%0d", t, HREADY, HRESP, err_cnt, exp_cnt);
         end
      end
      HTRANS = 2'b00;
      tick();
   endtask

   task automatic test_back_to_back();
      HADDR  = 32'h6000_0000;
      HTRANS = 2'b10;
      #1;
      tick();
      n_checks++; if (HREADY !== 1'b0 || HRESP !== 1'b1) begin n_errors++; $display("FAIL b2b_err1a: got ready=%b resp=%b want 0/1", HREADY, HRESP); end
      tick();
      exp_cnt = exp_cnt + 8'd1;
      n_checks++; if (HREADY !== 1'b1 || HRESP !== 1'b1 || err_cnt !== exp_cnt) begin n_errors++; $display("FAIL b2b_err2a: got ready=%b resp=%b cnt=%0d want 1/1/%0d", HREADY, HRESP, err_cnt, exp_cnt); end
      tick();
      HADDR = 32'h5100_0008;
      #1;
      n_checks++; if (HREADY !== 1'b0 || HRESP !== 1'b1) begin n_errors++; $display("FAIL b2b_err1b: got ready=%b resp=%b want 0/1", HREADY, HRESP); end
      tick();
      exp_cnt = exp_cnt + 8'd1;
      n_checks++; if (HREADY !== 1'b1 || HRESP !== 1'b1 || err_cnt !== exp_cnt) begin n_errors++; $display("FAIL b2b_err2b: got ready=%b resp=%b cnt=%0d want 1/1/%0d", HREADY, HRESP, err_cnt, exp_cnt); end
      tick();
      HTRANS = 2'b00;
      #1;
      n_checks++; if (HRDATA !== 32'hA5A5_A5A5 || HRESP !== 1'b0 || HREADY !== 1'b1) begin n_errors++; $display("FAIL b2b_mapped: got data=%h resp=%b ready=%b want a5a5a5a5/0/1", HRDATA, HRESP, HREADY); end
      tick();
   endtask

   task automatic test_wait();
      HADDR  = 32'h0000_0010;
      HTRANS = 2'b10;
      #1;
      tick();
      HREADYOUT_S[0] = 1'b0;
      HADDR = 32'h5100_0000;
      for (int c = 0; c < 3; c++) begin
         #1;
         n_checks++;
         if (HREADY !== 1'b0 || HRDATA !== 32'h1111_EEEE) begin
            n_errors++; $display("FAIL wait_hold[%0d]: got ready=%b data=%h want 0/1111eeee", c, HREADY, HRDATA);
         end
         tick();
      end
      HREADYOUT_S[0] = 1'b1;
      #1;
      n_checks++; if (HREADY !== 1'b1 || HRDATA !== 32'h1111_EEEE) begin n_errors++; $display("FAIL wait_release: got ready=%b data=%h want 1/1111eeee", HREADY, HRDATA); end
      tick();
      HTRANS = 2'b00;
      #1;
      n_checks++; if (HRDATA !== 32'hA5A5_A5A5 || HREADY !== 1'b1) begin n_errors++; $display("FAIL wait_pipelined: got data=%h ready=%b want a5a5a5a5/1", HRDATA, HREADY); end
      tick();
   endtask

   task automatic test_slave_error();
      HADDR  = 32'h5300_0000;
      HTRANS = 2'b10;
      #1;
      tick();
      HTRANS = 2'b00;
      HRESP_S[3] = 1'b1;
      HREADYOUT_S[3] = 1'b0;
      #1;
      n_checks++; if (HREADY !== 1'b0 || HRESP !== 1'b1) begin n_errors++; $display("FAIL slverr_first: got ready=%b resp=%b want 0/1", HREADY, HRESP); end
      tick();
      HREADYOUT_S[3] = 1'b1;
      #1;
      n_checks++; if (HREADY !== 1'b1 || HRESP !== 1'b1) begin n_errors++; $display("FAIL slverr_second: got ready=%b resp=%b want 1/1", HREADY, HRESP); end
      tick();
      HRESP_S[3] = 1'b0;
      #1;
      n_checks++; if (err_cnt !== exp_cnt) begin n_errors++; $display("FAIL slverr_not_counted: got %0d want %0d", err_cnt, exp_cnt); end
   endtask

   task automatic test_saturation();
      for (int k = 0; k < 300; k++) begin
         HADDR  = 32'h6000_0000;
         HTRANS = 2'b10;
         #1;
         tick();
         HTRANS = 2'b00;
         tick();
         tick();
      end
      exp_cnt = 8'd255;
      n_checks++; if (err_cnt !== exp_cnt) begin n_errors++; $display("FAIL sat_errcnt: got %0d want 255", err_cnt); end
      HTRANS = 2'b10;
      #1;
      tick();
      n_checks++; if (HREADY !== 1'b0 || HRESP !== 1'b1) begin n_errors++; $display("FAIL rst_err1_entry: got ready=%b resp=%b want 0/1", HREADY, HRESP); end
      HRESET = 1'b1;
      HTRANS = 2'b00;
      tick();
      HRESET = 1'b0;
      exp_cnt = 8'd0;
      #1;
      n_checks++; if (HREADY !== 1'b1 || HRESP !== 1'b0 || err_cnt !== exp_cnt) begin n_errors++; $display("FAIL rst_in_err1: got ready=%b resp=%b cnt=%0d want 1/0/0", HREADY, HRESP, err_cnt); end
      tick();
      n_checks++; if (HREADY !== 1'b1 || HRESP !== 1'b0) begin n_errors++; $display("FAIL rst_err1_clean: got ready=%b resp=%b want 1/0", HREADY, HRESP); end
   endtask

   task automatic test_reset_in_wait();
      HADDR  = 32'h0000_0000;
      HTRANS = 2'b10;
      #1;
      tick();
      HTRANS = 2'b00;
      HREADYOUT_S[0] = 1'b0;
      #1;
      n_checks++; if (HREADY !== 1'b0) begin n_errors++; $display("FAIL rstwait_stall: got %b want 0", HREADY); end
      HRESET = 1'b1;
      tick();
      HRESET = 1'b0;
      #1;
      n_checks++; if (HREADY !== 1'b1 || HRESP !== 1'b0 || HRDATA !== 32'h0) begin n_errors++; $display("FAIL rstwait_clean: got ready=%b resp=%b data=%h want 1/0/0", HREADY, HRESP, HRDATA); end
      HREADYOUT_S[0] = 1'b1;
      tick();
   endtask

`ifdef AHB_FABRIC_TIMEOUT_EN
   task automatic test_timeout();
      HADDR  = 32'h5000_0000;
      HTRANS = 2'b10;
      #1;
      tick();
      HTRANS = 2'b00;
      HREADYOUT_S[1] = 1'b0;
      for (int c = 0; c < 8; c++) begin
         #1;
         n_checks++;
         if (HREADY !== 1'b0 || timeout !== 1'b0) begin
            n_errors++; $display("FAIL to_stall[%0d]: got ready=%b timeout=%b want 0/0", c, HREADY, timeout);
         end
         tick();
      end
      HREADYOUT_S[1] = 1'b1;
      #1;
      n_checks++; if (timeout !== 1'b1 || HREADY !== 1'b0 || HRESP !== 1'b1) begin n_errors++; $display("FAIL to_fire: got timeout=%b ready=%b resp=%b want 1/0/1", timeout, HREADY, HRESP); end
      tick();
      exp_cnt = exp_cnt + 8'd1;
      n_checks++; if (timeout !== 1'b0 || HREADY !== 1'b1 || HRESP !== 1'b1 || err_cnt !== exp_cnt) begin n_errors++; $display("FAIL to_err2: got timeout=%b ready=%b resp=%b cnt=%0d want 0/1/1/%0d", timeout, HREADY, HRESP, err_cnt, exp_cnt); end
      tick();
   endtask
`else
   task automatic test_timeout();
      HADDR  = 32'h5000_0000;
      HTRANS = 2'b10;
      #1;
      tick();
      HTRANS = 2'b00;
      HREADYOUT_S[1] = 1'b0;
      repeat (12) tick();
      n_checks++; if (HREADY !== 1'b0 || timeout !== 1'b0) begin n_errors++; $display("FAIL no_timeout: got ready=%b timeout=%b want 0/0", HREADY, timeout); end
      HREADYOUT_S[1] = 1'b1;
      #1;
      n_checks++; if (HREADY !== 1'b1 || HRESP !== 1'b0 || HRDATA !== 32'h2222_DDDD) begin n_errors++; $display("FAIL no_timeout_done: got ready=%b resp=%b data=%h want 1/0/2222dddd", HREADY, HRESP, HRDATA); end
      tick();
   endtask
`endif

   initial begin
      test_reset();
      test_decode();
      test_unmapped();
      test_back_to_back();
      test_wait();
      test_slave_error();
      test_saturation();
      test_reset_in_wait();
      test_timeout();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
